// File: rtl/wasca_ram_arbiter.sv
// ---------------------------------------------------------------------------
// wasca_ram_arbiter
//   Shares the single-port on-chip RAM (DEPTH x 32) between two Avalon-MM
//   requesters. Port 0 is the Saturn bus bridge (latency critical). Port 1 is
//   the Nios/SD side. At most one command is forwarded to the RAM per clock.
//   Read data returns to the issuing port exactly one cycle after acceptance.
//
//   Parameters
//     DEPTH          implemented 32-bit words; addresses >= DEPTH are absorbed
//     PRIORITY_MODE  1 = port 0 priority with starvation guard, 0 = round-robin
//     STARVE_LIMIT   denied cycles of port 1 before it is forced to win (1..255)
//
//   Ports
//     clk, reset                       clock, async active-high reset
//     pN_address/byteenable/read/
//       write/writedata                Avalon-MM command inputs, N = 0,1
//     pN_waitrequest                   high = command not accepted this cycle
//     pN_readdata/readdatavalid        read return (data shared, valid per port)
//     ram_*                            single RAM port; ram_readdata comes from
//                                      a RAM with registered address and
//                                      unregistered output
// ---------------------------------------------------------------------------
module wasca_ram_arbiter #(
  parameter int DEPTH         = 6144,
  parameter int PRIORITY_MODE = 1,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] p0_address,
  input  logic [3:0]  p0_byteenable,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [31:0] p0_writedata,
  output logic        p0_waitrequest,
  output logic [31:0] p0_readdata,
  output logic        p0_readdatavalid,
  input  logic [12:0] p1_address,
  input  logic [3:0]  p1_byteenable,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [31:0] p1_writedata,
  output logic        p1_waitrequest,
  output logic [31:0] p1_readdata,
  output logic        p1_readdatavalid,
  output logic [12:0] ram_address,
  output logic [3:0]  ram_byteenable,
  output logic        ram_chipselect,
  output logic        ram_write,
  output logic [31:0] ram_writedata,
  input  logic [31:0] ram_readdata
);

  localparam logic [13:0] DEPTH_W = 14'(DEPTH);
  localparam logic [7:0]  LIMIT   = 8'(STARVE_LIMIT);

  logic       req0;
  logic       req1;
  logic       grant0;
  logic       grant1;
  logic       grant_any;
  logic       sel_write;
  logic       in_range;
  logic       p1_wins_tie;
  logic       last;
  logic [7:0] starve_cnt;
  logic [1:0] rd_owner;
  logic       rd_oor;

  // Both arbitration registers are always read so the unused mode's state
  // simply trims away in synthesis.
  assign p1_wins_tie = (PRIORITY_MODE == 1) ? (starve_cnt == LIMIT) : !last;

  always_comb begin
    req0   = p0_read | p0_write;
    req1   = p1_read | p1_write;
    grant1 = req1 && (!req0 || p1_wins_tie);
    grant0 = req0 && !grant1;
  end

  assign grant_any      = grant0 | grant1;
  assign p0_waitrequest = req0 & ~grant0;
  assign p1_waitrequest = req1 & ~grant1;

  // Idle cycles steer port 0's fields to the RAM, keeping its bus stable.
  assign ram_address    = grant1 ? p1_address    : p0_address;
  assign ram_byteenable = grant1 ? p1_byteenable : p0_byteenable;
  assign ram_writedata  = grant1 ? p1_writedata  : p0_writedata;
  // Read+write together counts as a write.
  assign sel_write      = grant1 ? p1_write      : p0_write;

  assign in_range       = {1'b0, ram_address} < DEPTH_W;
  assign ram_chipselect = grant_any & in_range;
  assign ram_write      = ram_chipselect & sel_write;

  // ---- stage boundary: accept edge -> read return cycle ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner   <= 2'b00;
      rd_oor     <= 1'b0;
      starve_cnt <= 8'd0;
      last       <= 1'b1;
    end else begin
      rd_owner <= {grant1 & ~p1_write, grant0 & ~p0_write};
      rd_oor   <= ~in_range;
      if (grant1)
        starve_cnt <= 8'd0;
      else if (req1 && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 8'd1;
      if (grant_any)
        last <= grant1;
    end
  end

  // Out-of-range reads never touched the RAM, so its output is masked to zero.
  assign p0_readdata      = rd_oor ? 32'h0 : ram_readdata;
  assign p1_readdata      = rd_oor ? 32'h0 : ram_readdata;
  assign p0_readdatavalid = rd_owner[0];
  assign p1_readdatavalid = rd_owner[1];

endmodule
